pipeline_ctrl: RTL
==================

# pipeline_ctrl

Pipeline sequencing controller for the 5-stage CPU. It drives the stage-register write enables and flushes from four conditions: load-use hazards the forwarding network cannot cover, taken branches resolved in EX, instruction- and data-memory stalls, and the halt drain sequence. It sits beside the forwarding unit in the decode/execute control path and also keeps saturating stall and flush performance counters.

## Interface
- MEM_TIMEOUT, 64: consecutive dmem_stall cycles that set mem_err.
- CNT_W, 16: width of the performance counters.
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- fd_Rs, fd_Rt  in  3 each  source registers of the instruction in IF/ID.
- fd_uses_Rs, fd_uses_Rt  in  1 each  the IF/ID instruction actually reads that source.
- fd_halt  in  1  the IF/ID instruction is HALT.
- de_mem_rd  in  1  the ID/EX instruction is a load.
- de_write_reg  in  3  destination register of the ID/EX instruction.
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- imem_stall  in  1  instruction memory is not ready.
- dmem_stall  in  1  data memory is busy; the MEM stage must hold.
- pc_wr_en, fd_wr_en, de_wr_en, em_wr_en, mw_wr_en  out  1 each  PC and stage-register write enables.
- fd_flush, de_flush  out  1 each  load a NOP bubble into IF/ID or ID/EX.
- halted  out  1  pipeline fully drained after HALT; sticky.
- mem_err  out  1  dmem watchdog expired; sticky.
- stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters.

## Operation
- States: RUN, MEM_WAIT, DRAIN, HALTED. Reset state is RUN; drain_cnt=0, wait_cnt=0, both counters 0, halted=0, mem_err=0.
- Reset outputs: while rst=1, all write enables are 0, fd_flush=de_flush=1, and halted, mem_err and both counters read 0.
- load_use = de_mem_rd & ((fd_uses_Rs & fd_Rs==de_write_reg) | (fd_uses_Rt & fd_Rt==de_write_reg)).
- RUN priority, highest first:
  1. dmem_stall: all enables 0, no flush. Next state MEM_WAIT.
  2. ex_branch_taken: all enables 1, fd_flush=de_flush=1. flush_cnt increments. An fd_halt in the same cycle is discarded.
  3. load_use: pc_wr_en=fd_wr_en=0, de_flush=1, de/em/mw enables 1. Exactly one bubble; the condition clears once the bubble advances.
  4. imem_stall: pc_wr_en=0, fd_flush=1, other enables 1.
  5. fd_halt: pc_wr_en=0, fd_flush=1, other enables 1. Next state DRAIN with drain_cnt=3.
  6. Otherwise all enables 1, no flush.
- MEM_WAIT:
  - dmem_stall=1: all enables 0; wait_cnt increments.
  - dmem_stall=0: the RUN rules apply in that same cycle; next state RUN; wait_cnt cleared.
- mem_err: set when wait_cnt reaches MEM_TIMEOUT (counting from the RUN entry cycle); held until rst.
- DRAIN:
  - pc_wr_en=0, fd_flush=1, other enables 1; ex_branch_taken is ignored.
  - dmem_stall freezes all enables and holds drain_cnt.
  - Otherwise drain_cnt decrements each cycle; at 1→0 the next state is HALTED.
- HALTED: all enables 0, no flush, halted=1. Only rst exits.
- stall_cnt: increments in every cycle with pc_wr_en=0 and state≠HALTED. Both counters saturate at all-ones.

## Timing
- All enables and flushes are combinational from the current state and inputs, with zero-cycle latency.
- State, drain_cnt, wait_cnt, counters, halted and mem_err update on posedge clk.
- halted rises exactly 4 un-stalled cycles after the cycle fd_halt is accepted.
- An async rst in any state immediately forces the reset outputs; the first post-reset edge with rst=0 runs RUN rules.

## Structure
- Package cpu_ctrl_pkg: state enum (RUN, MEM_WAIT, DRAIN, HALTED), DRAIN_DEPTH=3, register-index width 3.
- Sub-module hazard_detect: combinational load_use compare, reusable by other control blocks.

## Test plan
- Load-use: de_mem_rd=1, de_write_reg=3, fd_Rs=3, fd_uses_Rs=1 → one cycle with pc_wr_en=fd_wr_en=0, de_flush=1; stall_cnt=1; next cycle enables all 1.
- Load-use false match: same registers with fd_uses_Rs=0 → no stall.
- Branch with halt: ex_branch_taken=1 and fd_halt=1 together → fd_flush=de_flush=1, state stays RUN, flush_cnt=1.
- Memory stall during hazard: dmem_stall for 5 cycles during a load_use → all enables 0 for 5 cycles, then the load-use bubble in the release cycle; mem_err=0.
- Watchdog: MEM_TIMEOUT=8, dmem_stall held 10 cycles → mem_err=1 from the 8th cycle, stays 1 after release until rst.
- Halt drain: fd_halt accepted, with dmem_stall for 2 cycles mid-drain → halted rises 6 cycles after acceptance; enables stay 0 afterwards; async rst mid-DRAIN → state RUN, halted=0 immediately.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the CPU pipeline sequencing controller.
package cpu_ctrl_pkg;

    localparam int REG_W       = 3;
    localparam int DRAIN_DEPTH = 3;
    localparam int DRAIN_W     = 2;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_wr_en;
        logic fd_wr_en;
        logic de_wr_en;
        logic em_wr_en;
        logic mw_wr_en;
        logic fd_flush;
        logic de_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN    = ctrl_t'(7'b11111_00);
    localparam ctrl_t CTRL_FREEZE = ctrl_t'(7'b00000_00);
    localparam ctrl_t CTRL_RESET  = ctrl_t'(7'b00000_11);

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle of hazard conditions into, and stage controls out of, the pipeline controller.
interface pipeline_ctrl_if #(parameter int CNT_W = 16);
    import cpu_ctrl_pkg::*;

    // No valid/ready pairs: every input is a level condition valid each cycle,
    // and every enable/flush is the controller's same-cycle combinational answer.
    logic [REG_W-1:0] fd_Rs;
    logic [REG_W-1:0] fd_Rt;
    logic             fd_uses_Rs;
    logic             fd_uses_Rt;
    logic             fd_halt;
    logic             de_mem_rd;
    logic [REG_W-1:0] de_write_reg;
    logic             ex_branch_taken;
    logic             imem_stall;
    logic             dmem_stall;

    logic             pc_wr_en;
    logic             fd_wr_en;
    logic             de_wr_en;
    logic             em_wr_en;
    logic             mw_wr_en;
    logic             fd_flush;
    logic             de_flush;
    logic             halted;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output fd_Rs, fd_Rt, fd_uses_Rs, fd_uses_Rt, fd_halt, de_mem_rd,
               de_write_reg, ex_branch_taken, imem_stall, dmem_stall,
        input  pc_wr_en, fd_wr_en, de_wr_en, em_wr_en, mw_wr_en,
               fd_flush, de_flush, halted, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  fd_Rs, fd_Rt, fd_uses_Rs, fd_uses_Rt, fd_halt, de_mem_rd,
               de_write_reg, ex_branch_taken, imem_stall, dmem_stall,
        output pc_wr_en, fd_wr_en, de_wr_en, em_wr_en, mw_wr_en,
               fd_flush, de_flush, halted, mem_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in ID/EX writes a register the IF/ID instruction reads.
module hazard_detect
    import cpu_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] fd_Rs,
    input  logic [REG_W-1:0] fd_Rt,
    input  logic             fd_uses_Rs,
    input  logic             fd_uses_Rt,
    input  logic             de_mem_rd,
    input  logic [REG_W-1:0] de_write_reg,
    output logic             load_use
);

    assign load_use = de_mem_rd &
                      ((fd_uses_Rs & (fd_Rs == de_write_reg)) |
                       (fd_uses_Rt & (fd_Rt == de_write_reg)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: stage enables/flushes for hazards, branches,
// memory stalls and HALT drain, plus dmem watchdog and saturating perf counters.
module pipeline_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic            clk,
    input  logic            rst,
    pipeline_ctrl_if.slave  bus,
    output state_t          state_dbg
);

    localparam int              WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_t              state, state_next;
    logic [DRAIN_W-1:0]  drain_cnt, drain_next;
    logic [WAIT_W-1:0]   wait_cnt, wait_next;
    logic [CNT_W-1:0]    stall_cnt, flush_cnt;
    logic                mem_err;
    logic                load_use;
    logic                branch_flush;
    logic                stall_inc;
    ctrl_t               ctrl;

    hazard_detect u_hazard (
        .fd_Rs        (bus.fd_Rs),
        .fd_Rt        (bus.fd_Rt),
        .fd_uses_Rs   (bus.fd_uses_Rs),
        .fd_uses_Rt   (bus.fd_uses_Rt),
        .de_mem_rd    (bus.de_mem_rd),
        .de_write_reg (bus.de_write_reg),
        .load_use     (load_use)
    );

    always_comb begin
        ctrl         = CTRL_RUN;
        state_next   = state;
        drain_next   = drain_cnt;
        branch_flush = 1'b0;
        case (state)
            // MEM_WAIT falls back onto the RUN rules in its release cycle.
            RUN, MEM_WAIT: begin
                if (bus.dmem_stall) begin
                    ctrl       = CTRL_FREEZE;
                    state_next = MEM_WAIT;
                end else begin
                    state_next = RUN;
                    if (bus.ex_branch_taken) begin
                        ctrl.fd_flush = 1'b1;
                        ctrl.de_flush = 1'b1;
                        branch_flush  = 1'b1;
                    end else if (load_use) begin
                        ctrl.pc_wr_en = 1'b0;
                        ctrl.fd_wr_en = 1'b0;
                        ctrl.de_flush = 1'b1;
                    end else if (bus.imem_stall) begin
                        ctrl.pc_wr_en = 1'b0;
                        ctrl.fd_flush = 1'b1;
                    end else if (bus.fd_halt) begin
                        ctrl.pc_wr_en = 1'b0;
                        ctrl.fd_flush = 1'b1;
                        state_next    = DRAIN;
                        drain_next    = DRAIN_W'(DRAIN_DEPTH);
                    end
                end
            end
            DRAIN: begin
                if (bus.dmem_stall) begin
                    ctrl = CTRL_FREEZE;
                end else begin
                    ctrl.pc_wr_en = 1'b0;
                    ctrl.fd_flush = 1'b1;
                    drain_next    = drain_cnt - DRAIN_W'(1);
                    if (drain_cnt == DRAIN_W'(1)) state_next = HALTED;
                end
            end
            default: ctrl = CTRL_FREEZE;
        endcase
        if (rst) ctrl = CTRL_RESET;
    end

    // The stall that leaves RUN is the first counted watchdog cycle.
    always_comb begin
        wait_next = '0;
        if (bus.dmem_stall) begin
            if (state == RUN)
                wait_next = WAIT_W'(1);
            else if (state == MEM_WAIT)
                wait_next = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);
        end
    end

    assign stall_inc = ~ctrl.pc_wr_en & (state != HALTED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= '0;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
            wait_cnt  <= wait_next;
            if (wait_next == WAIT_MAX) mem_err <= 1'b1;
            if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (branch_flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign bus.pc_wr_en  = ctrl.pc_wr_en;
    assign bus.fd_wr_en  = ctrl.fd_wr_en;
    assign bus.de_wr_en  = ctrl.de_wr_en;
    assign bus.em_wr_en  = ctrl.em_wr_en;
    assign bus.mw_wr_en  = ctrl.mw_wr_en;
    assign bus.fd_flush  = ctrl.fd_flush;
    assign bus.de_flush  = ctrl.de_flush;
    assign bus.halted    = (state == HALTED);
    assign bus.mem_err   = mem_err;
    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;
    assign state_dbg     = state;

endmodule
